ext_arbiter: RTL and testbench

EXT_ARBITER -- requirements
Module: ext_arbiter

---
 rtl/ext_arbiter_pkg.sv | 16 +
 rtl/ext_arbiter_ext.sv | 28 ++
 rtl/ext_arbiter.sv | 84 ++++++++
 tb/tb_ext_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ext_arbiter_pkg.sv
// Shared constants for the extension-op arbiter: op codes and FSM state encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ext_arbiter_pkg;

    // Extension-op codes
    localparam logic [1:0] EOP_ZERO = 2'd0;  // zero-extend
    localparam logic [1:0] EOP_SIGN = 2'd1;  // sign-extend
    localparam logic [1:0] EOP_LUI  = 2'd2;  // imm in upper half, lower half zero
    localparam logic [1:0] EOP_BR   = 2'd3;  // sign-extend then shift left by 2

    // Output-register FSM state encoding
    localparam logic [0:0] EMPTY = 1'b0;     // no result held
    localparam logic [0:0] FULL  = 1'b1;     // result held, out_valid=1

endpackage

// File: rtl/ext_arbiter_ext.sv
// Combinational immediate extender: widens a 16-bit immediate to 32 bits by op code.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: imm[15:0] immediate in, eop[EOP_W-1:0] op code in, ext[31:0] extended value out.
module ext_arbiter_ext
    import ext_arbiter_pkg::*;
#(
    parameter int EOP_W = 2
) (
    input  logic [15:0]      imm,
    input  logic [EOP_W-1:0] eop,
    output logic [31:0]      ext
);

    always_comb begin
        ext = '0;
        case (eop)
            EOP_W'(EOP_ZERO): ext = {16'h0000, imm};
            EOP_W'(EOP_SIGN): ext = {{16{imm[15]}}, imm};
            EOP_W'(EOP_LUI):  ext = {imm, 16'h0000};
            // Sign-extended value shifted by 2; the two bits pushed out of
            // bit 31 are dropped, leaving 14 copies of the sign bit on top.
            EOP_W'(EOP_BR):   ext = {{14{imm[15]}}, imm, 2'b00};
            default:          ext = '0;
        endcase
    end

endmodule

// File: rtl/ext_arbiter.sv
// Two-requester round-robin arbiter feeding an immediate extender into a one-entry output register.
// Latency: 1 cycle from grant edge to out_valid/out_data/out_src.
// Backpressure: requesters are granted only when the output register is empty or being popped the same cycle.
// Ports: clk, rst_n (async active-low); r0_*/r1_* valid/ready request channels carrying imm[15:0] and eop;
//        out_valid/out_ready result channel carrying out_data[31:0] and out_src (winning requester index).
module ext_arbiter
    import ext_arbiter_pkg::*;
#(
    parameter int EOP_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             r0_valid,
    output logic             r0_ready,
    input  logic [15:0]      r0_imm,
    input  logic [EOP_W-1:0] r0_eop,

    input  logic             r1_valid,
    output logic             r1_ready,
    input  logic [15:0]      r1_imm,
    input  logic [EOP_W-1:0] r1_eop,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_src
);

    logic [0:0]       state;
    logic             last_grant;
    logic             accept_ok;
    logic             grant;
    logic             grant_idx;
    logic [15:0]      sel_imm;
    logic [EOP_W-1:0] sel_eop;
    logic [31:0]      ext_val;

    // The register can take a new result when it is empty, or when the
    // consumer drains it on this same edge (pop + load, no bubble).
    assign accept_ok = (state == EMPTY) || out_ready;

    // On a tie the requester that did not win last time goes first; a lone
    // requester always wins regardless of history. rst_n gating keeps both
    // readies low for the whole reset interval.
    assign grant_idx = (r0_valid && r1_valid) ? ~last_grant : r1_valid;
    assign grant     = rst_n && accept_ok && (r0_valid || r1_valid);

    assign r0_ready = grant && !grant_idx;
    assign r1_ready = grant &&  grant_idx;

    assign sel_imm = grant_idx ? r1_imm : r0_imm;
    assign sel_eop = grant_idx ? r1_eop : r0_eop;

    ext_arbiter_ext #(
        .EOP_W (EOP_W)
    ) ext (
        .imm (sel_imm),
        .eop (sel_eop),
        .ext (ext_val)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_src    <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (grant) begin
                state      <= FULL;
                out_data   <= ext_val;
                out_src    <= grant_idx;
                last_grant <= grant_idx;
            end else if ((state == FULL) && out_ready) begin
                // Pop with nothing to refill; data left as-is, out_valid drops.
                state <= EMPTY;
            end
        end
    end

    assign out_valid = (state == FULL);

endmodule

// File: tb/tb_ext_arbiter.sv
module tb_ext_arbiter;

    logic        clk;
    logic        rst_n;
    logic        r0_valid, r1_valid;
    logic        r0_ready, r1_ready;
    logic [15:0] r0_imm, r1_imm;
    logic [1:0]  r0_eop, r1_eop;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        out_src;

    int vectors     = 0;
    int miscompares = 0;

    ext_arbiter #(.EOP_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .r0_valid  (r0_valid),
        .r0_ready  (r0_ready),
        .r0_imm    (r0_imm),
        .r0_eop    (r0_eop),
        .r1_valid  (r1_valid),
        .r1_ready  (r1_ready),
        .r1_imm    (r1_imm),
        .r1_eop    (r1_eop),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference extension computed arithmetically from the op definitions.
    function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [1:0] op);
        int u;
        int s;
        u = int'(imm);
        s = (u >= 32768) ? (u - 65536) : u;
        case (op)
            2'd0:    return 32'(u);
            2'd1:    return 32'(s);
            2'd2:    return 32'(u * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic drive(input logic v0, input logic [15:0] i0, input logic [1:0] e0,
                         input logic v1, input logic [15:0] i1, input logic [1:0] e1,
                         input logic ordy);
        r0_valid  = v0;
        r0_imm    = i0;
        r0_eop    = e0;
        r1_valid  = v1;
        r1_imm    = i1;
        r1_eop    = e1;
        out_ready = ordy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulses reset off the clock edge; leaves inputs idle, released before the next edge.
    task automatic do_reset;
        drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, 1'b1);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic drain;
        drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, 1'b1);
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b1, 16'h1111, 2'd0, 1'b1, 16'h2222, 2'd0, 1'b1);
        tick();
        vectors++;
        if ({out_valid, out_data, out_src} !== 34'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b d=%h s=%b expected 0/0/0", out_valid, out_data, out_src);
        end
        vectors++;
        if ({r0_ready, r1_ready} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_ready: got %b%b expected 00", r0_ready, r1_ready);
        end
        rst_n = 1'b1;
        drive(1'b1, 16'h00AB, 2'd0, 1'b0, 16'h0, 2'd0, 1'b1);
        #1;
        vectors++;
        if (r0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL first_grant_ready: got %b expected 1", r0_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h0000_00AB) begin
            miscompares++;
            $display("FAIL first_grant_out: got v=%b d=%h expected 1/000000ab", out_valid, out_data);
        end
        drain();
    endtask

    task automatic test_op_ext;
        logic [15:0] imms [3];
        logic [1:0]  ops  [3];
        logic [31:0] exps [3];
        imms = '{16'hFFFF, 16'hFFFF, 16'h1234};
        ops  = '{2'd3, 2'd0, 2'd2};
        exps = '{32'hFFFF_FFFC, 32'h0000_FFFF, 32'h1234_0000};
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, imms[k], ops[k], 1'b0, 16'h0, 2'd0, 1'b1);
            #1;
            vectors++;
            if (r0_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL op_ext_ready[%0d]: got %b expected 1", k, r0_ready);
            end
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exps[k] || out_src !== 1'b0) begin
                miscompares++;
                $display("FAIL op_ext[%0d]: got v=%b d=%h s=%b expected 1/%h/0", k, out_valid, out_data, out_src, exps[k]);
            end
        end
        drain();
    endtask

    task automatic test_sign_ext;
        logic [15:0] imms [2];
        logic [31:0] exps [2];
        imms = '{16'h8000, 16'h7FFF};
        exps = '{32'hFFFF_8000, 32'h0000_7FFF};
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, imms[k], 2'd1, 1'b0, 16'h0, 2'd0, 1'b1);
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== exps[k]) begin
                miscompares++;
                $display("FAIL sign_ext[%0d]: got v=%b d=%h expected 1/%h", k, out_valid, out_data, exps[k]);
            end
        end
        drain();
    endtask

    task automatic test_tie;
        logic        exp_src;
        logic [31:0] exp_dat;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'(k), 2'd0, 1'b1, 16'(100 + k), 2'd0, 1'b1);
            #1;
            exp_src = (k % 2 == 1);
            exp_dat = exp_src ? 32'(100 + k) : 32'(k);
            vectors++;
            if (r0_ready !== !exp_src || r1_ready !== exp_src) begin
                miscompares++;
                $display("FAIL tie_ready[%0d]: got %b%b expected %b%b", k, r0_ready, r1_ready, !exp_src, exp_src);
            end
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_src !== exp_src || out_data !== exp_dat) begin
                miscompares++;
                $display("FAIL tie_out[%0d]: got v=%b s=%b d=%h expected 1/%b/%h", k, out_valid, out_src, out_data, exp_src, exp_dat);
            end
        end
        drain();
    endtask

    task automatic test_backpressure;
        do_reset();
        drive(1'b1, 16'h00A5, 2'd0, 1'b0, 16'h0, 2'd0, 1'b1);
        tick();
        // Held result, both requesters waiting, consumer stalled.
        drive(1'b1, 16'h0B0B, 2'd0, 1'b1, 16'h0C0C, 2'd2, 1'b0);
        for (int k = 0; k < 5; k++) begin
            #1;
            vectors++;
            if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_ready[%0d]: got %b%b expected 00", k, r0_ready, r1_ready);
            end
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_data !== 32'h0000_00A5 || out_src !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h s=%b expected 1/000000a5/0", k, out_valid, out_data, out_src);
            end
        end
        // Release: tie with last winner r0, so r1 loads on the same edge as the pop.
        out_ready = 1'b1;
        #1;
        vectors++;
        if (r0_ready !== 1'b0 || r1_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release_ready: got %b%b expected 01", r0_ready, r1_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 32'h0C0C_0000 || out_src !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_pop_load: got v=%b d=%h s=%b expected 1/0c0c0000/1", out_valid, out_data, out_src);
        end
        drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, 1'b1);
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pop_to_empty: got v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_lone;
        int          outs;
        logic [31:0] exp_dat;
        do_reset();
        outs = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 16'h0, 2'd0, 1'b1, 16'(16'h4000 + k), 2'd0, 1'b1);
            #1;
            vectors++;
            if (r1_ready !== 1'b1 || r0_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL lone_ready[%0d]: got %b%b expected 01", k, r0_ready, r1_ready);
            end
            tick();
            exp_dat = 32'(32'h4000 + k);
            if (out_valid === 1'b1 && out_src === 1'b1 && out_data === exp_dat) outs++;
        end
        vectors++;
        if (outs !== 4) begin
            miscompares++;
            $display("FAIL lone_results: got %0d expected 4", outs);
        end
        drain();
    endtask

    task automatic test_mid_reset;
        do_reset();
        drive(1'b1, 16'h5555, 2'd0, 1'b0, 16'h0, 2'd0, 1'b0);
        tick();
        drive(1'b1, 16'h6666, 2'd0, 1'b1, 16'h7777, 2'd0, 1'b1);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_async: got v=%b d=%h rdy=%b%b expected 0/0/00", out_valid, out_data, r0_ready, r1_ready);
        end
        rst_n = 1'b1;
        #1;
        vectors++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_tie: got %b%b expected 10", r0_ready, r1_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_src !== 1'b0 || out_data !== 32'h0000_6666) begin
            miscompares++;
            $display("FAIL mid_reset_out: got v=%b s=%b d=%h expected 1/0/00006666", out_valid, out_src, out_data);
        end
        drain();
    endtask

    task automatic test_random;
        logic        m_full, m_src, m_last;
        logic [31:0] m_data;
        logic        v0, v1, ordy, acc, g, w;
        logic [15:0] i0, i1;
        logic [1:0]  e0, e1;
        do_reset();
        m_full = 1'b0;
        m_src  = 1'b0;
        m_last = 1'b1;
        m_data = 32'h0;
        for (int n = 0; n < 400; n++) begin
            v0   = 1'($urandom_range(0, 1));
            v1   = 1'($urandom_range(0, 1));
            i0   = 16'($urandom);
            i1   = 16'($urandom);
            e0   = 2'($urandom_range(0, 3));
            e1   = 2'($urandom_range(0, 3));
            ordy = ($urandom_range(0, 3) != 0);
            drive(v0, i0, e0, v1, i1, e1, ordy);
            #1;
            acc = !m_full || ordy;
            g   = acc && (v0 || v1);
            w   = (v0 && v1) ? !m_last : v1;
            vectors++;
            if (r0_ready !== (g && !w) || r1_ready !== (g && w)) begin
                miscompares++;
                $display("FAIL rand_ready[%0d]: got %b%b expected %b%b", n, r0_ready, r1_ready, g && !w, g && w);
            end
            tick();
            if (g) begin
                m_full = 1'b1;
                m_data = w ? ref_ext(i1, e1) : ref_ext(i0, e0);
                m_src  = w;
                m_last = w;
            end else if (m_full && ordy) begin
                m_full = 1'b0;
            end
            vectors++;
            if (out_valid !== m_full || (m_full && (out_data !== m_data || out_src !== m_src))) begin
                miscompares++;
                $display("FAIL rand_out[%0d]: got v=%b d=%h s=%b expected %b/%h/%b", n, out_valid, out_data, out_src, m_full, m_data, m_src);
            end
        end
        drain();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 16'h0, 2'd0, 1'b0, 16'h0, 2'd0, 1'b0);
        test_reset();
        test_op_ext();
        test_sign_ext();
        test_tie();
        test_backpressure();
        test_lone();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
